alu_seq_engine: RTL

Parametrised multi-cycle ALU sequencer: the next generation of the CPU's ALU controller. It accepts one operation per req/ack handshake, snapshots its operands, and runs arithmetic through the shared external narrow adder one slice per step. Logic, variable-distance shifts and compare run locally. Full C/Z/N/V flags and an error acknowledge for illegal function codes are added. It sits between the instruction decoder/control unit and the shared adder.

---
 rtl/alu_seq_engine.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_engine.sv
// Multi-cycle ALU sequencer: arithmetic runs through a shared external narrow adder one slice
// at a time; logic, single-bit-per-cycle shifts and CHK run locally.
module alu_seq_engine #(
   parameter int PA_DATA       = 32,
   parameter int PA_FNCT       = 9,
   parameter int PA_ADDER_DATA = 8
) (
   input  logic                     clk,
   input  logic                     rst_b,
   input  logic [PA_DATA-1:0]       inp_a,
   input  logic [PA_DATA-1:0]       inp_b,
   input  logic [PA_FNCT-1:0]       fnct_sel,
   input  logic                     alu_req,
   input  logic [PA_ADDER_DATA-1:0] adder_out,
   input  logic                     carry_out,
   output logic [PA_DATA-1:0]       alu_out,
   output logic                     alu_ack,
   output logic                     alu_err,
   output logic [PA_ADDER_DATA-1:0] adder_in_a,
   output logic [PA_ADDER_DATA-1:0] adder_in_b,
   output logic                     carry_in,
   output logic                     cf,
   output logic                     zf,
   output logic                     nf,
   output logic                     vf,
   output logic [3:0]               dbg_state
);

   // Handshake: an op is taken when alu_req=1 is sampled in IDLE while alu_ack is low;
   // alu_ack is a one-cycle pulse, so at least one idle cycle separates consecutive ops.

   localparam int NUM_SLICES = PA_DATA / PA_ADDER_DATA;
   localparam int KW         = $clog2(NUM_SLICES) + 1;
   localparam int SW         = $clog2(PA_DATA);
   localparam int OPW        = PA_FNCT - 3;
   localparam int MSB        = PA_DATA - 1;

   typedef enum logic [3:0] {
      S_IDLE, S_ARITH, S_WAIT, S_SAMPLE, S_LOGIC, S_SHIFT, S_CHK, S_ERR, S_ACK
   } state_t;

   state_t               state;
   logic [PA_DATA-1:0]   a_r, b_r, res_r, res_next, logic_res;
   logic [2:0]           op_r;
   logic [SW-1:0]        cnt;
   logic [KW-1:0]        k;
   logic                 cin_r, a_msb, b_msb, sc_r, shifted_r;

   logic [2:0]           cls;
   logic [OPW-1:0]       op_f;
   logic                 is_chk, is_arith, is_logic, is_shift, inv_b, cin_init, v_next;

   assign dbg_state = state;
   assign cls  = fnct_sel[PA_FNCT-1 -: 3];
   assign op_f = fnct_sel[OPW-1:0];

   always_comb begin
      is_chk   = (cls == 3'd0);
      is_arith = (cls == 3'd1) && (op_f <= OPW'(4));
      is_logic = (cls == 3'd2) && (op_f <= OPW'(2));
      is_shift = (cls == 3'd2) && (op_f >= OPW'(3)) && (op_f <= OPW'(5));
      inv_b    = is_arith && ((op_f == OPW'(1)) || (op_f == OPW'(3)) || (op_f == OPW'(4)));
      cin_init = 1'b0;
      case (op_f[2:0])
         3'd1, 3'd4: cin_init = 1'b1;
         3'd2, 3'd3: cin_init = cf;
         default:    cin_init = 1'b0;
      endcase
   end

   // Sampled slices enter from the top, so after the last slice res_next is the full sum.
   if (NUM_SLICES > 1) begin : g_multi
      assign res_next = {adder_out, res_r[PA_DATA-1:PA_ADDER_DATA]};
   end else begin : g_single
      assign res_next = adder_out;
   end

   assign v_next = (a_msb == b_msb) && (res_next[MSB] != a_msb);

   always_comb begin
      logic_res = a_r & b_r;
      case (op_r)
         3'd1:    logic_res = a_r | b_r;
         3'd2:    logic_res = a_r ^ b_r;
         default: logic_res = a_r & b_r;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state      <= S_IDLE;
         alu_out    <= '0;
         alu_ack    <= 1'b0;
         alu_err    <= 1'b0;
         adder_in_a <= '0;
         adder_in_b <= '0;
         carry_in   <= 1'b0;
         cf         <= 1'b0;
         zf         <= 1'b0;
         nf         <= 1'b0;
         vf         <= 1'b0;
         a_r        <= '0;
         b_r        <= '0;
         res_r      <= '0;
         op_r       <= '0;
         cnt        <= '0;
         k          <= '0;
         cin_r      <= 1'b0;
         a_msb      <= 1'b0;
         b_msb      <= 1'b0;
         sc_r       <= 1'b0;
         shifted_r  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               alu_ack <= 1'b0;
               alu_err <= 1'b0;
               if (alu_req && !alu_ack) begin
                  a_r       <= inp_a;
                  b_r       <= inv_b ? ~inp_b : inp_b;
                  a_msb     <= inp_a[MSB];
                  b_msb     <= inv_b ? ~inp_b[MSB] : inp_b[MSB];
                  op_r      <= op_f[2:0];
                  cnt       <= inp_b[SW-1:0];
                  shifted_r <= |inp_b[SW-1:0];
                  cin_r     <= cin_init;
                  k         <= '0;
                  if (is_chk)        state <= S_CHK;
                  else if (is_arith) state <= S_ARITH;
                  else if (is_logic) state <= S_LOGIC;
                  else if (is_shift) state <= S_SHIFT;
                  else               state <= S_ERR;
               end
            end
            S_ARITH: begin
               adder_in_a <= a_r[PA_ADDER_DATA-1:0];
               adder_in_b <= b_r[PA_ADDER_DATA-1:0];
               carry_in   <= cin_r;
               a_r        <= a_r >> PA_ADDER_DATA;
               b_r        <= b_r >> PA_ADDER_DATA;
               state      <= S_WAIT;
            end
            S_WAIT: state <= S_SAMPLE;
            S_SAMPLE: begin
               res_r    <= res_next;
               carry_in <= carry_out;
               if (k == KW'(NUM_SLICES - 1)) begin
                  if (op_r != 3'd4) alu_out <= res_next;
                  cf    <= carry_out;
                  zf    <= (res_next == '0);
                  nf    <= res_next[MSB];
                  vf    <= v_next;
                  state <= S_ACK;
               end else begin
                  adder_in_a <= a_r[PA_ADDER_DATA-1:0];
                  adder_in_b <= b_r[PA_ADDER_DATA-1:0];
                  a_r        <= a_r >> PA_ADDER_DATA;
                  b_r        <= b_r >> PA_ADDER_DATA;
                  k          <= k + 1'b1;
                  state      <= S_WAIT;
               end
            end
            S_LOGIC: begin
               alu_out <= logic_res;
               zf      <= (logic_res == '0);
               nf      <= logic_res[MSB];
               state   <= S_ACK;
            end
            S_CHK: begin
               alu_out <= a_r;
               zf      <= (a_r == '0);
               nf      <= a_r[MSB];
               state   <= S_ACK;
            end
            S_SHIFT: begin
               if (cnt == '0) begin
                  alu_out <= a_r;
                  zf      <= (a_r == '0);
                  nf      <= a_r[MSB];
                  if (shifted_r) cf <= sc_r;
                  state   <= S_ACK;
               end else begin
                  case (op_r)
                     3'd3: begin
                        sc_r <= a_r[MSB];
                        a_r  <= a_r << 1;
                     end
                     3'd4: begin
                        sc_r <= a_r[0];
                        a_r  <= a_r >> 1;
                     end
                     default: begin
                        sc_r <= a_r[0];
                        a_r  <= {a_r[MSB], a_r[MSB:1]};
                     end
                  endcase
                  cnt <= cnt - 1'b1;
               end
            end
            S_ERR: begin
               alu_ack <= 1'b1;
               alu_err <= 1'b1;
               state   <= S_IDLE;
            end
            S_ACK: begin
               alu_ack <= 1'b1;
               alu_err <= 1'b0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
